// File: rtl/pll_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pll_seq_ctrl
// Brief   : Power-up / lock sequencer for the core PLL, running on the PLL
//           reference clock. It gates the core clock and core reset on lock.
// Revision: 1.0 - initial release
// ============================================================================
module pll_seq_ctrl #(
   parameter int PWRUP_CYC    = 4,
   parameter int SETTLE_CYC   = 16,
   parameter int LOCK_STABLE  = 8,
   parameter int LOCK_TIMEOUT = 64,
   parameter int OFF_CYC      = 8,
   parameter int RST_HOLD     = 4,
   parameter int MAX_RETRY    = 3,
   parameter int CW           = 8
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       pll_req,
   input  logic       lock_det,
   output logic       en_vco,
   output logic       clk_gate_en,
   output logic       core_rst_n,
   output logic       pll_locked,
   output logic       pll_fail,
   output logic [1:0] retry_cnt,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_PWRUP     = 3'd1,
      S_SETTLE    = 3'd2,
      S_LOCKCHK   = 3'd3,
      S_RETRY_OFF = 3'd4,
      S_RELEASE   = 3'd5,
      S_RUN       = 3'd6,
      S_FAIL      = 3'd7
   } state_t;

   // Every wait starts from a counter load of 0, so it ends at N-1.
   localparam logic [CW-1:0] c_pwrup_last   = CW'(PWRUP_CYC - 1);
   localparam logic [CW-1:0] c_settle_last  = CW'(SETTLE_CYC - 1);
   localparam logic [CW-1:0] c_timeout_last = CW'(LOCK_TIMEOUT - 1);
   localparam logic [CW-1:0] c_off_last     = CW'(OFF_CYC - 1);
   localparam logic [CW-1:0] c_hold_last    = CW'(RST_HOLD - 1);
   localparam logic [CW-1:0] c_lock_stable  = CW'(LOCK_STABLE);
   localparam logic [CW-1:0] c_cnt_max      = '1;
   localparam logic [CW-1:0] c_one          = CW'(1);
   localparam logic [1:0]    c_max_retry    = 2'(MAX_RETRY);

   state_t        r_state;
   state_t        w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;
   logic [CW-1:0] w_cnt_inc;
   logic [CW-1:0] r_stab;
   logic [CW-1:0] w_stab_nxt;
   logic [CW-1:0] w_stab_inc;
   logic [1:0]    r_retry;
   logic [1:0]    w_retry_nxt;
   logic          r_sync1;
   logic          r_sync2;
   logic          r_en_vco;
   logic          r_clk_gate_en;
   logic          r_core_rst_n;
   logic          r_pll_locked;
   logic          r_pll_fail;

   assign w_cnt_inc  = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + c_one;
   assign w_stab_inc = (r_stab == c_cnt_max) ? r_stab : r_stab + c_one;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = w_cnt_inc;
      w_stab_nxt  = '0;
      w_retry_nxt = r_retry;
      if ((r_state != S_IDLE) && !pll_req) begin
         // Dropping the request aborts from anywhere and forgets past retries.
         w_state_nxt = S_IDLE;
         w_cnt_nxt   = '0;
         w_retry_nxt = '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               w_cnt_nxt = '0;
               if (pll_req) w_state_nxt = S_PWRUP;
            end
            S_PWRUP: begin
               if (r_cnt == c_pwrup_last) begin
                  w_state_nxt = S_SETTLE;
                  w_cnt_nxt   = '0;
               end
            end
            S_SETTLE: begin
               if (r_cnt == c_settle_last) begin
                  w_state_nxt = S_LOCKCHK;
                  w_cnt_nxt   = '0;
               end
            end
            S_LOCKCHK: begin
               w_stab_nxt = r_sync2 ? w_stab_inc : '0;
               // Lock is tested first so it wins over a simultaneous timeout.
               if (w_stab_nxt == c_lock_stable) begin
                  w_state_nxt = S_RELEASE;
                  w_cnt_nxt   = '0;
                  w_stab_nxt  = '0;
               end else if (r_cnt == c_timeout_last) begin
                  w_cnt_nxt  = '0;
                  w_stab_nxt = '0;
                  if (r_retry < c_max_retry) begin
                     w_state_nxt = S_RETRY_OFF;
                     w_retry_nxt = r_retry + 2'd1;
                  end else begin
                     w_state_nxt = S_FAIL;
                  end
               end
            end
            S_RETRY_OFF: begin
               if (r_cnt == c_off_last) begin
                  w_state_nxt = S_SETTLE;
                  w_cnt_nxt   = '0;
               end
            end
            S_RELEASE: begin
               if (r_cnt == c_hold_last) begin
                  w_state_nxt = S_RUN;
                  w_cnt_nxt   = '0;
               end
            end
            S_RUN: begin
               w_cnt_nxt = '0;
               if (!r_sync2) w_state_nxt = S_LOCKCHK;
            end
            S_FAIL: begin
               w_cnt_nxt = '0;
            end
            default: begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
            end
         endcase
      end
   end

   // Outputs are decoded from the next state so they align with r_state.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_sync1       <= 1'b0;
         r_sync2       <= 1'b0;
         r_state       <= S_IDLE;
         r_cnt         <= '0;
         r_stab        <= '0;
         r_retry       <= '0;
         r_en_vco      <= 1'b0;
         r_clk_gate_en <= 1'b0;
         r_core_rst_n  <= 1'b0;
         r_pll_locked  <= 1'b0;
         r_pll_fail    <= 1'b0;
      end else begin
         r_sync1       <= lock_det;
         r_sync2       <= r_sync1;
         r_state       <= w_state_nxt;
         r_cnt         <= w_cnt_nxt;
         r_stab        <= w_stab_nxt;
         r_retry       <= w_retry_nxt;
         r_en_vco      <= (w_state_nxt == S_SETTLE) || (w_state_nxt == S_LOCKCHK) ||
                          (w_state_nxt == S_RELEASE) || (w_state_nxt == S_RUN);
         r_clk_gate_en <= (w_state_nxt == S_RELEASE) || (w_state_nxt == S_RUN);
         r_core_rst_n  <= (w_state_nxt == S_RUN);
         r_pll_locked  <= (w_state_nxt == S_RUN);
         r_pll_fail    <= (w_state_nxt == S_FAIL);
      end
   end

   assign en_vco      = r_en_vco;
   assign clk_gate_en = r_clk_gate_en;
   assign core_rst_n  = r_core_rst_n;
   assign pll_locked  = r_pll_locked;
   assign pll_fail    = r_pll_fail;
   assign retry_cnt   = r_retry;
   assign state       = r_state;

endmodule
`default_nettype wire

// File: doc/pll_seq_ctrl.md
Name: pll_seq_ctrl

Overview:
- Power-up and lock sequencer for the analog PLL (avsd_pll_1v8) that clocks the RVMyth core. Runs on the PLL reference clock.
- Drives the VCO enable and waits for a settle time. Qualifies an external lock-detect flag, retries on timeout, and only then enables the core clock gate and releases core reset.
- Sits between the top-level power/reset logic and the PLL + core.

Parameters:
- PWRUP_CYC, 4: ref cycles from request to EN_VCO assertion.
- SETTLE_CYC, 16: ref cycles after EN_VCO before lock is monitored. The PLL needs ≥2 REF edges to update its period.
- LOCK_STABLE, 8: consecutive synced lock_det=1 cycles required to declare lock.
- LOCK_TIMEOUT, 64: max ref cycles in LOCKCHK before a retry.
- OFF_CYC, 8: ref cycles EN_VCO is held low between retries.
- RST_HOLD, 4: ref cycles between clk_gate_en rising and core_rst_n release.
- MAX_RETRY, 3: retries allowed before FAIL.
- CW, 8: width of the shared cycle counter; must hold the largest cycle parameter.

Ports:
- CLK  input  1  reference clock; the same net as the PLL REF.
- RST_N  input  1  synchronous active-low reset.
- pll_req  input  1  level; 1 = bring the PLL up and keep it running, 0 = shut it down.
- lock_det  input  1  asynchronous lock flag from the lock detector.
- en_vco  output  1  drives PLL EN_VCO.
- clk_gate_en  output  1  enables the PLL clock to the core.
- core_rst_n  output  1  active-low core reset.
- pll_locked  output  1  sequence complete, core running.
- pll_fail  output  1  retries exhausted.
- retry_cnt  output  2  retries used so far.
- state  output  3  encoded FSM state, for debug.

Behaviour:
- Reset (RST_N=0 at a CLK edge):
  - state=IDLE (0), counter=0, retry_cnt=0.
  - en_vco=0, clk_gate_en=0, core_rst_n=0, pll_locked=0, pll_fail=0.
- lock_det passes through a 2-flop synchroniser (reset to 0) before any use. Its latency from input to FSM is 2 cycles.
- All outputs are registered, decoded from the next state. Each counter load is 0, and each wait lasts exactly N cycles.
- States and encodings:
  - IDLE=0: when pll_req=1, go to PWRUP and clear the counter.
  - PWRUP=1: count PWRUP_CYC cycles, then go to SETTLE with en_vco=1.
  - SETTLE=2: en_vco=1. After SETTLE_CYC cycles, go to LOCKCHK.
  - LOCKCHK=3:
    - Maintain a stable counter: increment on synced lock=1, clear on 0.
    - When it reaches LOCK_STABLE, go to RELEASE with clk_gate_en=1.
    - Otherwise, when the timeout counter reaches LOCK_TIMEOUT:
      - If retry_cnt<MAX_RETRY, go to RETRY_OFF and increment retry_cnt.
      - Else go to FAIL.
    - If the stable threshold and the timeout are reached in the same cycle, lock wins.
  - RETRY_OFF=4: en_vco=0. After OFF_CYC cycles, go to SETTLE (en_vco=1).
  - RELEASE=5: clk_gate_en=1, core_rst_n=0. After RST_HOLD cycles, go to RUN.
  - RUN=6: en_vco=1, clk_gate_en=1, core_rst_n=1, pll_locked=1.
    - If synced lock drops for 1 cycle, go to LOCKCHK with core_rst_n=0, clk_gate_en=0, pll_locked=0, en_vco kept 1, and a fresh timeout.
    - retry_cnt is not cleared in this case.
  - FAIL=7: en_vco=0, pll_fail=1, everything else inactive. Leave only when pll_req=0, then go to IDLE.
- pll_req=0 in any state other than IDLE:
  - Next cycle goes to IDLE with all outputs at their reset values.
  - retry_cnt and pll_fail clear.
  - This overrides all other transitions in the same cycle.
- Ordering:
  - core_rst_n never rises unless clk_gate_en has been 1 for exactly RST_HOLD cycles.
  - clk_gate_en never is 1 while en_vco=0.
- Counters are saturating and cannot wrap. retry_cnt width supports MAX_RETRY ≤ 3.

Test Plan:
- Nominal lock, with all parameters at their defaults:
  - Stimulus: RST_N released, pll_req=1 at cycle 0, lock_det=1 from cycle 20.
  - Required: en_vco rises at cycle 5; clk_gate_en rises once 8 synced-high cycles are seen in LOCKCHK; core_rst_n rises 4 cycles later; pll_locked=1; retry_cnt=0.
- Lock never arrives:
  - Stimulus: lock_det held 0.
  - Required: 3 RETRY_OFF episodes, each with en_vco low for 8 cycles; retry_cnt goes 1, 2, 3; then FAIL with pll_fail=1 and en_vco=0; dropping pll_req returns to IDLE with retry_cnt=0.
- Chatter:
  - Stimulus: lock_det toggles every 4 cycles in LOCKCHK.
  - Required: never locks (stable counter resets); timeout triggers a retry at exactly 64 cycles.
- Loss of lock in RUN:
  - Stimulus: lock_det drops for 3 cycles.
  - Required: core_rst_n=0, clk_gate_en=0 at 2+1 cycles after the drop; en_vco stays 1; relock gives RELEASE then RUN again.
- Mid-sequence abort:
  - Stimulus: pll_req=0 during SETTLE, then separately during RELEASE.
  - Required: next cycle IDLE with all outputs 0/inactive; core_rst_n stays 0.
- Synchronous reset:
  - Stimulus: RST_N=0 for 1 cycle while in RUN, then re-check with RST_N=0 but no CLK edge.
  - Required: outputs go to reset values only at the CLK edge; no change without a CLK edge.
